// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: padder FSM states, padding helpers, and the
// round-constant / initial-hash tables used by the compression core.
package sha256_pkg;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, OUT, DONE} padder_state_t;

    localparam logic [31:0] PAD_WORD = 32'h80000000;

    // Message words plus the 0x80 marker word and the two length words.
    function automatic int num_blocks(input int n);
        return (n + 3 + 15) / 16;
    endfunction

    // Value of any non-memory word; the upper length word is always 0 for n <= 1024.
    function automatic logic [31:0] pad_word(input int idx, input int n);
        int total;
        total = 16 * num_blocks(n);
        if (idx == n)
            return PAD_WORD;
        else if (idx == total - 1)
            return 32'(n * 32);
        else
            return 32'h0;
    endfunction

    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [0:7][31:0] H0 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

endpackage

// File: rtl/sha256_msg_padder.sv
// Reads a message from word memory and streams it SHA-256 padded, 16 words per block.
// Define PADDER_BSWAP_EN to byte-swap memory words before they are emitted.
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int NUM_OF_WORDS = 20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] message_addr,
    output logic        busy,
    output logic        done,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    input  logic [31:0] mem_read_data,
    output logic        blk_valid,
    input  logic        blk_ready,
    output logic [31:0] blk_word,
    output logic        blk_first,
    output logic        blk_last,
    output logic        blk_final
);

    localparam int NUM_BLOCKS  = num_blocks(NUM_OF_WORDS);
    localparam int TOTAL_WORDS = 16 * NUM_BLOCKS;
    localparam int IDX_W       = $clog2(TOTAL_WORDS) + 1;

    padder_state_t    r_state;
    logic [IDX_W-1:0] r_idx;
    logic [15:0]      r_base;
    logic [31:0]      r_word;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;

    logic             w_in_msg;
    logic             w_last_word;
    logic [31:0]      w_mem_word;

    assign w_in_msg    = (r_idx < IDX_W'(NUM_OF_WORDS));
    assign w_last_word = (r_idx == IDX_W'(TOTAL_WORDS - 1));

`ifdef PADDER_BSWAP_EN
    assign w_mem_word = {mem_read_data[7:0], mem_read_data[15:8],
                         mem_read_data[23:16], mem_read_data[31:24]};
`else
    assign w_mem_word = mem_read_data;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_base  <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_base  <= message_addr;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    if (w_in_msg) begin
                        r_state <= WAIT;
                    end else begin
                        r_word  <= pad_word(int'(r_idx), NUM_OF_WORDS);
                        r_valid <= 1'b1;
                        r_state <= OUT;
                    end
                end
                WAIT: begin
                    r_word  <= w_mem_word;
                    r_valid <= 1'b1;
                    r_state <= OUT;
                end
                OUT: begin
                    if (blk_ready) begin
                        r_valid <= 1'b0;
                        if (w_last_word) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= FETCH;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_idx   <= '0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Address is presented only in FETCH; memory returns data during WAIT.
    assign mem_addr  = (r_state == FETCH && w_in_msg) ? (r_base + 16'(r_idx)) : 16'h0;
    assign mem_clk   = clk;
    assign mem_we    = 1'b0;

    assign busy      = r_busy;
    assign done      = r_done;
    assign blk_valid = r_valid;
    assign blk_word  = r_word;
    assign blk_first = r_valid && (r_idx[3:0] == 4'd0);
    assign blk_last  = r_valid && (r_idx[3:0] == 4'd15);
    assign blk_final = r_valid && (r_idx >= IDX_W'(TOTAL_WORDS - 16));

endmodule
